// File: rtl/ad_capture_buffer.sv
// Purpose: threshold-triggered snapshot of the ADC pair stream, replayed in chronological order.
// Latency: input to RAM write 1 cycle; RD_EN to RD_DATA/RD_VALID 1 cycle.
// Backpressure: none on the ADC side; readout advances only on RD_EN while DONE is high.
// Optional feature: AD_CAPTURE_TIMEOUT_EN adds a WAIT_TRIG timeout auto-trigger.
module ad_capture_buffer #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned PRE_TRIG   = 64,
    parameter logic [23:0] TIMEOUT    = 24'd1000000
) (
    input  logic        QCLK,
    input  logic        RESET,
    input  logic [7:0]  DI,
    input  logic [7:0]  DID,
    input  logic        ARM,
    input  logic [7:0]  THRESH,
    input  logic        RD_EN,
    output logic [15:0] RD_DATA,
    output logic        RD_VALID,
    output logic        BUSY,
    output logic        DONE,
    output logic        AUTO_TRIG
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam int unsigned POST_LEN = DEPTH - PRE_TRIG - 1;
    localparam logic [DEPTH_LOG2-1:0] PRE_W     = DEPTH_LOG2'(PRE_TRIG);
    localparam logic [DEPTH_LOG2-1:0] PRE_LAST  = DEPTH_LOG2'(PRE_TRIG - 1);
    localparam logic [DEPTH_LOG2-1:0] POST_LAST = DEPTH_LOG2'(POST_LEN - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FILL = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_READ = 3'd4;

    logic [2:0]            state;
    logic [7:0]            di_r;
    logic [7:0]            did_r;
    logic [7:0]            thresh_l;
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;
    logic [DEPTH_LOG2-1:0] post_cnt;
    logic [DEPTH_LOG2-1:0] rd_cnt;
    logic [15:0]           ram [DEPTH];
    logic                  wr_en;
    logic                  trig_hit;
    logic                  tmo_hit;

    // Two's-complement magnitude; -128 maps to 128, which still fits 8 bits unsigned.
    function automatic logic [7:0] mag(input logic [7:0] x);
        return x[7] ? (~x + 8'd1) : x;
    endfunction

    assign trig_hit = (mag(di_r) >= thresh_l) || (mag(did_r) >= thresh_l);
    assign wr_en    = (state == S_FILL) || (state == S_WAIT) || (state == S_POST);
    assign BUSY     = wr_en;
    assign DONE     = (state == S_READ);

    // Register the sample pair once; everything downstream works on these copies.
    always_ff @(posedge QCLK) begin
        if (RESET) begin
            di_r  <= 8'd0;
            did_r <= 8'd0;
        end else begin
            di_r  <= DI;
            did_r <= DID;
        end
    end

`ifdef AD_CAPTURE_TIMEOUT_EN
    logic [23:0] tmo_cnt;
    logic        auto_trig_r;

    assign tmo_hit   = (state == S_WAIT) && (tmo_cnt == TIMEOUT - 24'd1);
    assign AUTO_TRIG = auto_trig_r;

    // Count WAIT_TRIG cycles (zero elsewhere, so every entry restarts at 0); flag timeout-ended captures.
    always_ff @(posedge QCLK) begin
        if (RESET) begin
            tmo_cnt     <= 24'd0;
            auto_trig_r <= 1'b0;
        end else begin
            tmo_cnt <= (state == S_WAIT) ? tmo_cnt + 24'd1 : 24'd0;
            if (state == S_IDLE && ARM)
                auto_trig_r <= 1'b0;
            else if (tmo_hit && !trig_hit)
                auto_trig_r <= 1'b1;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign AUTO_TRIG = 1'b0;
`endif

    // Capture/readout sequencer: pre-fill, wait for trigger, post-fill, then chronological readout.
    always_ff @(posedge QCLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            wp       <= '0;
            rp       <= '0;
            post_cnt <= '0;
            rd_cnt   <= '0;
            thresh_l <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ARM) begin
                        thresh_l <= THRESH;
                        wp       <= '0;
                        state    <= (PRE_TRIG == 0) ? S_WAIT : S_FILL;
                    end
                end
                S_FILL: begin
                    wp <= wp + 1'b1;
                    if (wp == PRE_LAST)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    wp <= wp + 1'b1;
                    if (trig_hit || tmo_hit) begin
                        // Oldest word of the window sits PRE_TRIG entries behind the trigger word.
                        rp       <= wp - PRE_W;
                        rd_cnt   <= '0;
                        post_cnt <= '0;
                        state    <= (POST_LEN == 0) ? S_READ : S_POST;
                    end
                end
                S_POST: begin
                    wp       <= wp + 1'b1;
                    post_cnt <= post_cnt + 1'b1;
                    if (post_cnt == POST_LAST)
                        state <= S_READ;
                end
                S_READ: begin
                    if (RD_EN) begin
                        rp     <= rp + 1'b1;
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == '1)
                            state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sample RAM write port; contents survive reset and are overwritten by the next capture.
    always_ff @(posedge QCLK) begin
        if (wr_en && !RESET)
            ram[wp] <= {did_r, di_r};
    end

    // Registered read port: one-cycle valid pulse per accepted RD_EN, data held between reads.
    always_ff @(posedge QCLK) begin
        if (RESET) begin
            RD_DATA  <= 16'd0;
            RD_VALID <= 1'b0;
        end else begin
            RD_VALID <= (state == S_READ) && RD_EN;
            if ((state == S_READ) && RD_EN)
                RD_DATA <= ram[rp];
        end
    end

endmodule

// File: tb/tb_ad_capture_buffer.sv
// Bench for ad_capture_buffer (DEPTH_LOG2=4, PRE_TRIG=4): behavioural window model plus literal pins.
module tb_ad_capture_buffer;

    localparam int DL2   = 4;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;

    logic        QCLK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  DI = 8'd0;
    logic [7:0]  DID = 8'd0;
    logic        ARM = 1'b0;
    logic [7:0]  THRESH = 8'd0;
    logic        RD_EN = 1'b0;
    logic [15:0] RD_DATA;
    logic        RD_VALID;
    logic        BUSY;
    logic        DONE;
    logic        AUTO_TRIG;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] rd_log [$];

    ad_capture_buffer #(.DEPTH_LOG2(DL2), .PRE_TRIG(PRE), .TIMEOUT(24'd1000000)) dut (
        .QCLK(QCLK), .RESET(RESET), .DI(DI), .DID(DID), .ARM(ARM), .THRESH(THRESH),
        .RD_EN(RD_EN), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .BUSY(BUSY),
        .DONE(DONE), .AUTO_TRIG(AUTO_TRIG)
    );

    always #5 QCLK = ~QCLK;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Captured words are kept as a plain list indexed from the ARM cycle; the
    // window is the DEPTH-word slice starting PRE words before the first
    // eligible word whose magnitude reaches the latched threshold.
    bit          m_ok = 0, m_busy = 0, m_read = 0, m_vld = 0;
    logic [15:0] m_data = 16'd0;
    logic [15:0] m_q [$];
    int          m_trig = -1, m_need = -1, m_rk = 0;
    int          m_th = 0;

    function automatic int mag(input logic [7:0] v);
        int u;
        u = int'(v);
        return (u >= 128) ? 256 - u : u;
    endfunction

    task automatic m_push(input logic [15:0] w);
        int idx;
        idx = m_q.size();
        m_q.push_back(w);
        if (m_trig < 0 && idx >= PRE && (mag(w[7:0]) >= m_th || mag(w[15:8]) >= m_th)) begin
            m_trig = idx;
            m_need = idx + DEPTH - PRE;
        end
    endtask

    // Compare process: check every cycle at the falling edge, then advance the model with this cycle's inputs.
    always @(negedge QCLK) begin
        if (m_ok) begin
            chk("busy", BUSY, m_busy);
            chk("done", DONE, m_read);
            chk("rd_valid", RD_VALID, m_vld);
            chk("rd_data", RD_DATA, m_data);
            chk("auto_trig", AUTO_TRIG, 0);
        end
        if (RD_VALID === 1'b1) rd_log.push_back(RD_DATA);
        if (RESET) begin
            m_busy = 0; m_read = 0; m_vld = 0; m_data = 16'd0;
            m_q.delete(); m_trig = -1; m_need = -1; m_ok = 1;
        end else begin
            m_vld = 0;
            if (m_read) begin
                if (RD_EN) begin
                    m_data = m_q[m_trig - PRE + m_rk];
                    m_vld  = 1;
                    m_rk++;
                    if (m_rk == DEPTH) m_read = 0;
                end
            end else if (m_busy) begin
                if (m_need > 0 && m_q.size() == m_need) begin
                    m_busy = 0; m_read = 1; m_rk = 0;
                end else begin
                    m_push({DID, DI});
                end
            end else if (ARM) begin
                m_th = int'(THRESH);
                m_q.delete(); m_trig = -1; m_need = -1;
                m_busy = 1;
                m_push({DID, DI});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge QCLK);
        #1;
    endtask

    // Pair k after ARM: 0 ramp + DI=0x50 at 20; 1 ramp + DID=-127 at 10, -128 at 30; 2 random; else ramp.
    function automatic logic [15:0] pat(input int mode, input int k);
        logic [7:0] a, b;
        a = 8'(k);
        b = 8'(k);
        case (mode)
            0: if (k == 20) a = 8'h50;
            1: begin
                if (k == 10) b = 8'h81;
                else if (k == 30) b = 8'h80;
            end
            2: begin a = 8'($urandom); b = 8'($urandom); end
            default: ;
        endcase
        return {b, a};
    endfunction

    // rd_mode: 0 continuous RD_EN, 1 random RD_EN/ARM, 2 repeating 1,0,1,1.
    task automatic capture(input int mode, input logic [7:0] th, input int rd_mode, input int abort_at);
        int k, guard;
        rd_log.delete();
        RD_EN = 1'b0;
        ARM = 1'b1; THRESH = th; {DID, DI} = pat(mode, 0);
        cyc();
        chk("busy_after_arm", BUSY, 1);
        ARM = 1'b0; THRESH = 8'($urandom);
        k = 1; guard = 0;
        while (DONE !== 1'b1 && guard < 3000) begin
            if (k == abort_at) begin
                ARM = 1'b0; RD_EN = 1'b0; RESET = 1'b1;
                cyc();
                RESET = 1'b0;
                chk("busy_after_reset", BUSY, 0);
                chk("done_after_reset", DONE, 0);
                return;
            end
            {DID, DI} = pat(mode, k);
            if (rd_mode == 1) begin ARM = 1'($urandom); RD_EN = 1'($urandom); end
            cyc(); k++; guard++;
        end
        ARM = 1'b0; RD_EN = 1'b0;
        if (DONE !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL capture_wait: DONE=%b after %0d cycles, required 1", DONE, guard);
            return;
        end
        k = 0; guard = 0;
        while (DONE === 1'b1 && guard < 500) begin
            {DID, DI} = pat(2, 0);
            case (rd_mode)
                0: RD_EN = 1'b1;
                1: begin RD_EN = 1'($urandom); ARM = 1'($urandom); end
                default: RD_EN = ((k % 4) != 1);
            endcase
            cyc(); k++; guard++;
        end
        ARM = 1'b0;
        if (DONE === 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL readout_wait: DONE still 1 after %0d cycles, required 0", guard);
        end
        RD_EN = 1'b1;
        cyc();
        chk("rd_valid_past_end", RD_VALID, 0);
        chk("done_past_end", DONE, 0);
        chk("busy_past_end", BUSY, 0);
        RD_EN = 1'b0;
        chk("read_count", rd_log.size(), DEPTH);
    endtask

    initial begin
        RESET = 1'b1;
        repeat (3) cyc();
        RESET = 1'b0;
        cyc();
        chk("reset_rd_data", RD_DATA, 0);
        chk("reset_rd_valid", RD_VALID, 0);
        chk("reset_busy", BUSY, 0);
        chk("reset_done", DONE, 0);
        chk("reset_auto_trig", AUTO_TRIG, 0);

        // Ramp with 0x50 at pair 20: window is pairs 16..31, trigger is read #5.
        capture(0, 8'h40, 0, -1);
        chk("ramp_first", rd_log[0], 16'h1010);
        chk("ramp_trigger", rd_log[4], 16'h1450);
        chk("ramp_last", rd_log[15], 16'h1F1F);

        // -127 must not reach 0x80; -128 must.
        capture(1, 8'h80, 0, -1);
        chk("neg128_first", rd_log[0], 16'h1A1A);
        chk("neg128_trigger", rd_log[4], 16'h801E);

        // Zero threshold: trigger on the first WAIT_TRIG word, RD_EN pattern 1,0,1,1.
        capture(3, 8'h00, 2, -1);
        chk("thr0_first", rd_log[0], 16'h0000);
        chk("thr0_last", rd_log[15], 16'h0F0F);

        // Reset while in POST, then a fresh capture must be fully rewritten.
        capture(0, 8'h40, 0, 22);
        repeat (2) cyc();
        capture(1, 8'h80, 1, -1);
        chk("rearm_trigger", rd_log[4], 16'h801E);

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) begin
                {DID, DI} = pat(2, 0);
                cyc();
            end
            capture(2, 8'($urandom_range(0, 127)), int'($urandom_range(0, 2)), -1);
        end

        repeat (3) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
